// File: rtl/gate_share_arb.sv
// gate_share_arb: round-robin arbiter in front of a single shared 1-bit gate.
// A granted requester's operands are latched and evaluated one cycle later.
// The result is registered with y_valid, y_id and a wrapping operation counter.
// Optional feature macro: GATE_ARB_OPSEL_EN adds the per-requester 2-bit op select
// (00 AND, 01 OR, 10 XOR, 11 NAND). When the macro is undefined the gate is AND only.
module gate_share_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     a,
    input  logic [N_REQ-1:0]     b,
`ifdef GATE_ARB_OPSEL_EN
    input  logic [2*N_REQ-1:0]   op,
`endif
    output logic [N_REQ-1:0]     gnt,
    output logic                 y,
    output logic                 y_valid,
    output logic [2:0]           y_id,
    output logic [CNT_W-1:0]     ops_cnt
);

    typedef enum logic {
        IDLE,
        EVAL
    } state_t;

    state_t              state;
    logic [2:0]          last_winner;
    logic                a_lat;
    logic                b_lat;
`ifdef GATE_ARB_OPSEL_EN
    logic [1:0]          op_lat;
    logic [1:0]          op_sel;
`endif

    logic [2*N_REQ-1:0]  req_dbl;
    logic [2*N_REQ-1:0]  req_rot;
    logic [3:0]          rot_sh;
    logic                found;
    logic [2:0]          win_idx;
    logic [N_REQ-1:0]    win_oh;
    logic                a_sel;
    logic                b_sel;
    logic                res;
    int unsigned         cand;

    // Round-robin pick: rotate req so the slot after last_winner sits at bit 0,
    // take the first set bit, then map the offset back to an absolute index.
    always_comb begin
        req_dbl = {req, req};
        rot_sh  = {1'b0, last_winner} + 4'd1;
        req_rot = req_dbl >> rot_sh;
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                cand  = 32'(last_winner) + 32'd1 + i;
                if (cand >= N_REQ) begin
                    cand = cand - N_REQ;
                end
                win_idx = 3'(cand);
            end
        end
        win_oh = found ? (N_REQ'(1) << win_idx) : '0;
        a_sel  = |(a & win_oh);
        b_sel  = |(b & win_oh);
    end

`ifdef GATE_ARB_OPSEL_EN
    // Select the winner's 2-bit op code using the one-hot grant vector.
    always_comb begin
        op_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                op_sel = op[2*i +: 2];
            end
        end
    end

    // Gate function chosen by the latched op code.
    always_comb begin
        case (op_lat)
            2'b00:   res = a_lat & b_lat;
            2'b01:   res = a_lat | b_lat;
            2'b10:   res = a_lat ^ b_lat;
            default: res = ~(a_lat & b_lat);
        endcase
    end
`else
    // Gate function: AND of the latched operands.
    always_comb begin
        res = a_lat & b_lat;
    end
`endif

    // Two-state FSM: IDLE grants and latches operands, EVAL publishes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            y           <= 1'b0;
            y_valid     <= 1'b0;
            y_id        <= '0;
            ops_cnt     <= '0;
            last_winner <= 3'(N_REQ - 1);
            a_lat       <= 1'b0;
            b_lat       <= 1'b0;
`ifdef GATE_ARB_OPSEL_EN
            op_lat      <= '0;
`endif
        end else begin
            y_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt         <= win_oh;
                        a_lat       <= a_sel;
                        b_lat       <= b_sel;
`ifdef GATE_ARB_OPSEL_EN
                        op_lat      <= op_sel;
`endif
                        last_winner <= win_idx;
                        state       <= EVAL;
                    end
                end
                EVAL: begin
                    y       <= res;
                    y_valid <= 1'b1;
                    y_id    <= last_winner;
                    gnt     <= '0;
                    ops_cnt <= ops_cnt + CNT_W'(1);
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_share_arb.sv
// Directed self-checking bench for gate_share_arb (N_REQ = 4, CNT_W = 4).
// Build with GATE_ARB_OPSEL_EN defined to also exercise the op-select feature.
module tb_gate_share_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
`ifdef GATE_ARB_OPSEL_EN
    logic [2*N-1:0] op;
`endif
    logic [N-1:0]  gnt;
    logic          y;
    logic          y_valid;
    logic [2:0]    y_id;
    logic [CW-1:0] ops_cnt;

    int            n_cmp;
    int            n_fail;
    logic [CW-1:0] exp_cnt;

    gate_share_arb #(
        .N_REQ (N),
        .CNT_W (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a       (a),
        .b       (b),
`ifdef GATE_ARB_OPSEL_EN
        .op      (op),
`endif
        .gnt     (gnt),
        .y       (y),
        .y_valid (y_valid),
        .y_id    (y_id),
        .ops_cnt (ops_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; a = '0; b = '0;
        #3;
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
        n_cmp++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL rst_y_valid got=%b want=0", y_valid); end
        n_cmp++; if (y !== 1'b0) begin n_fail++; $display("FAIL rst_y got=%b want=0", y); end
        n_cmp++; if (y_id !== 3'd0) begin n_fail++; $display("FAIL rst_y_id got=%0d want=0", y_id); end
        n_cmp++; if (ops_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_ops_cnt got=%0d want=0", ops_cnt); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_no_req_gnt got=%b want=0000", gnt); end
        req = 4'b0001; a = 4'b0001; b = 4'b0001;
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL first_arb_gnt got=%b want=0001", gnt); end
        // abort mid-EVAL
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL abort_gnt got=%b want=0000", gnt); end
        n_cmp++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL abort_y_valid got=%b want=0", y_valid); end
        n_cmp++; if (ops_cnt !== 4'd0) begin n_fail++; $display("FAIL abort_ops_cnt got=%0d want=0", ops_cnt); end
        req = '0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL post_abort_y_valid got=%b want=0", y_valid); end
        tick();
        n_cmp++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL post_abort_y_valid2 got=%b want=0", y_valid); end
        n_cmp++; if (ops_cnt !== 4'd0) begin n_fail++; $display("FAIL post_abort_ops_cnt got=%0d want=0", ops_cnt); end
        exp_cnt = '0;
    endtask

    task automatic test_truth_table();
        logic av;
        logic bv;
        logic y_prev;
        for (int v = 0; v < 4; v++) begin
            av = (v >= 2);
            bv = (v % 2 == 1);
            req = 4'b0100;
            a = {1'b0, av, 2'b00};
            b = {1'b0, bv, 2'b00};
            tick();
            n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL tt%0d_gnt got=%b want=0100", v, gnt); end
            n_cmp++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL tt%0d_early_valid got=%b want=0", v, y_valid); end
            req = '0; a = '0; b = '0;
            tick();
            exp_cnt = exp_cnt + 4'd1;
            n_cmp++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL tt%0d_valid got=%b want=1", v, y_valid); end
            n_cmp++; if (y !== (av & bv)) begin n_fail++; $display("FAIL tt%0d_y got=%b want=%b", v, y, av & bv); end
            n_cmp++; if (y_id !== 3'd2) begin n_fail++; $display("FAIL tt%0d_y_id got=%0d want=2", v, y_id); end
            n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL tt%0d_gnt_drop got=%b want=0000", v, gnt); end
            n_cmp++; if (ops_cnt !== exp_cnt) begin n_fail++; $display("FAIL tt%0d_ops_cnt got=%0d want=%0d", v, ops_cnt, exp_cnt); end
            y_prev = av & bv;
            tick();
            n_cmp++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL tt%0d_pulse_len got=%b want=0", v, y_valid); end
            n_cmp++; if (y !== y_prev) begin n_fail++; $display("FAIL tt%0d_y_hold got=%b want=%b", v, y, y_prev); end
            n_cmp++; if (y_id !== 3'd2) begin n_fail++; $display("FAIL tt%0d_y_id_hold got=%0d want=2", v, y_id); end
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] av;
        logic [N-1:0] bv;
        int unsigned  w;
        logic [N-1:0] exp_g;
        pulse_reset();
        av = 4'b1010; bv = 4'b1110;
        req = 4'b1111; a = av; b = bv;
        for (int k = 0; k < 5; k++) begin
            w = k % 4;
            exp_g = 4'b0001 << w;
            tick();
            n_cmp++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rr%0d_gnt got=%b want=%b", k, gnt, exp_g); end
            tick();
            exp_cnt = exp_cnt + 4'd1;
            n_cmp++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL rr%0d_valid got=%b want=1", k, y_valid); end
            n_cmp++; if (y_id !== 3'(w)) begin n_fail++; $display("FAIL rr%0d_y_id got=%0d want=%0d", k, y_id, w); end
            n_cmp++; if (y !== (av[w] & bv[w])) begin n_fail++; $display("FAIL rr%0d_y got=%b want=%b", k, y, av[w] & bv[w]); end
            n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr%0d_gap_gnt got=%b want=0000", k, gnt); end
            n_cmp++; if (ops_cnt !== exp_cnt) begin n_fail++; $display("FAIL rr%0d_ops_cnt got=%0d want=%0d", k, ops_cnt, exp_cnt); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_fairness();
        req = 4'b0010; a = 4'b0011; b = 4'b0011;
        tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL fair_first_gnt got=%b want=0010", gnt); end
        req = '0;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_cmp++; if (y_id !== 3'd1) begin n_fail++; $display("FAIL fair_first_id got=%0d want=1", y_id); end
        req = 4'b0011;
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL fair_next_gnt got=%b want=0001", gnt); end
        req = 4'b0010;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_cmp++; if (y_id !== 3'd0) begin n_fail++; $display("FAIL fair_next_id got=%0d want=0", y_id); end
        n_cmp++; if (y !== 1'b1) begin n_fail++; $display("FAIL fair_next_y got=%b want=1", y); end
        req = '0;
        tick();
    endtask

    task automatic test_skip();
        // last winner is 0; requesters 0 and 1 compete, 1 wins, 0 withdraws
        req = 4'b0011; a = 4'b0111; b = 4'b0111;
        tick();
        n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL skip_gnt1 got=%b want=0010", gnt); end
        req = 4'b0100;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_cmp++; if (y_id !== 3'd1) begin n_fail++; $display("FAIL skip_id1 got=%0d want=1", y_id); end
        tick();
        n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL skip_gnt2 got=%b want=0100", gnt); end
        req = '0;
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_cmp++; if (y_id !== 3'd2) begin n_fail++; $display("FAIL skip_id2 got=%0d want=2", y_id); end
        tick();
        n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL skip_no_gnt got=%b want=0000", gnt); end
        n_cmp++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL skip_no_valid got=%b want=0", y_valid); end
        n_cmp++; if (ops_cnt !== exp_cnt) begin n_fail++; $display("FAIL skip_ops_cnt got=%0d want=%0d", ops_cnt, exp_cnt); end
    endtask

    task automatic test_counter_wrap();
        pulse_reset();
        req = 4'b0001; a = 4'b0001; b = 4'b0001;
        for (int k = 1; k <= 17; k++) begin
            tick();
            tick();
            exp_cnt = exp_cnt + 4'd1;
            if (k == 16) begin
                n_cmp++; if (ops_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap16_ops_cnt got=%0d want=0", ops_cnt); end
            end
        end
        n_cmp++; if (ops_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap17_ops_cnt got=%0d want=1", ops_cnt); end
        n_cmp++; if (ops_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_model_ops_cnt got=%0d want=%0d", ops_cnt, exp_cnt); end
        req = '0;
        tick();
    endtask

`ifdef GATE_ARB_OPSEL_EN
    task automatic test_opsel();
        req = 4'b0001; a = 4'b0001; b = 4'b0001; op = 8'b0000_0011;
        tick();
        req = '0;
        tick();
        n_cmp++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL opsel_nand_valid got=%b want=1", y_valid); end
        n_cmp++; if (y !== 1'b0) begin n_fail++; $display("FAIL opsel_nand_y got=%b want=0", y); end
        req = 4'b0001; a = 4'b0001; b = 4'b0000; op = 8'b0000_0010;
        tick();
        req = '0;
        tick();
        n_cmp++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL opsel_xor_valid got=%b want=1", y_valid); end
        n_cmp++; if (y !== 1'b1) begin n_fail++; $display("FAIL opsel_xor_y got=%b want=1", y); end
        op = '0;
        tick();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        exp_cnt = '0;
        rst_n = 1'b0;
        req = '0; a = '0; b = '0;
`ifdef GATE_ARB_OPSEL_EN
        op = '0;
`endif
        test_reset();
        test_truth_table();
        test_round_robin();
        test_fairness();
        test_skip();
        test_counter_wrap();
`ifdef GATE_ARB_OPSEL_EN
        test_opsel();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
